// File: rtl/adder2comp_pkg.sv
// ============================================================================
// adder2comp_pkg: shared control-state encoding and default operand width.
// Rev 1.0
// ============================================================================
`default_nettype none

package adder2comp_pkg;

  localparam int ADDER2COMP_N = 4;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_AB    = 3'd1,
    LOAD_MAG   = 3'd2,
    COMP_MAG   = 3'd3,
    COMP_SIGNS = 3'd4,
    ADD_SUB    = 3'd5,
    LOAD_RES   = 3'd6,
    DONE       = 3'd7
  } state_t;

endpackage

`default_nettype wire

// File: rtl/uc_adder2comp.sv
// ============================================================================
// uc_adder2comp: control FSM that sequences the sign/magnitude adder datapath.
// Rev 1.0
// ============================================================================
`default_nettype none

module uc_adder2comp
  import adder2comp_pkg::*;
(
  input  logic clk,
  input  logic RESET,
  input  logic S,
  output logic loadAB,
  output logic loadmagAB,
  output logic compmag,
  output logic compsigns,
  output logic add_sub,
  output logic loadres,
  output logic done
);

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Strobes are masked by RESET so nothing fires while reset is being applied.
  always_comb begin
    state_d   = state_q;
    loadAB    = 1'b0;
    loadmagAB = 1'b0;
    compmag   = 1'b0;
    compsigns = 1'b0;
    add_sub   = 1'b0;
    loadres   = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE:       state_d = S ? LOAD_AB : IDLE;
      LOAD_AB:    begin state_d = LOAD_MAG;   loadAB    = !RESET; end
      LOAD_MAG:   begin state_d = COMP_MAG;   loadmagAB = !RESET; end
      COMP_MAG:   begin state_d = COMP_SIGNS; compmag   = !RESET; end
      COMP_SIGNS: begin state_d = ADD_SUB;    compsigns = !RESET; end
      ADD_SUB:    begin state_d = LOAD_RES;   add_sub   = !RESET; end
      LOAD_RES:   begin state_d = DONE;       loadres   = !RESET; end
      DONE:       begin state_d = IDLE;       done      = !RESET; end
      default:    state_d = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/adder2comp.sv
// ============================================================================
// adder2comp: multi-cycle two's-complement adder using a sign/magnitude datapath.
// Define ADDER2COMP_DBG_EN to expose the six control strobes as output ports.
// Rev 1.0
// ============================================================================
`default_nettype none

module adder2comp
  import adder2comp_pkg::*;
#(
  parameter int N = ADDER2COMP_N
) (
  input  logic         clk,
  input  logic         RESET,
  input  logic         S,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N:0]   result,
`ifdef ADDER2COMP_DBG_EN
  output logic         loadAB,
  output logic         loadmagAB,
  output logic         compmag,
  output logic         compsigns,
  output logic         add_sub,
  output logic         loadres,
`endif
  output logic         done
);

`ifndef ADDER2COMP_DBG_EN
  logic loadAB;
  logic loadmagAB;
  logic compmag;
  logic compsigns;
  logic add_sub;
  logic loadres;
`endif

  uc_adder2comp u_uc (
    .clk       (clk),
    .RESET     (RESET),
    .S         (S),
    .loadAB    (loadAB),
    .loadmagAB (loadmagAB),
    .compmag   (compmag),
    .compsigns (compsigns),
    .add_sub   (add_sub),
    .loadres   (loadres),
    .done      (done)
  );

  logic [N-1:0] a_q, a_d, b_q, b_d;
  logic         siga_q, siga_d, sigb_q, sigb_d;
  logic [N-1:0] maga_q, maga_d, magb_q, magb_d;
  logic         ge_q, ge_d, eq_q, eq_d;
  logic [N:0]   mag_q, mag_d;
  logic         sign_q, sign_d;
  logic [N:0]   result_q, result_d;

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    siga_d   = siga_q;
    sigb_d   = sigb_q;
    maga_d   = maga_q;
    magb_d   = magb_q;
    ge_d     = ge_q;
    eq_d     = eq_q;
    mag_d    = mag_q;
    sign_d   = sign_q;
    result_d = result_q;
    if (loadAB) begin
      a_d    = a;
      b_d    = b;
      siga_d = a[N-1];
      sigb_d = b[N-1];
    end
    // Negating the most negative value wraps to 2^(N-1), the correct unsigned magnitude.
    if (loadmagAB) begin
      maga_d = siga_q ? -a_q : a_q;
      magb_d = sigb_q ? -b_q : b_q;
    end
    if (compmag)   ge_d = (maga_q >= magb_q);
    if (compsigns) eq_d = (siga_q == sigb_q);
    if (add_sub) begin
      if (eq_q) begin
        mag_d  = {1'b0, maga_q} + {1'b0, magb_q};
        sign_d = siga_q;
      end else if (ge_q) begin
        mag_d  = {1'b0, maga_q - magb_q};
        sign_d = (maga_q == magb_q) ? 1'b0 : siga_q;
      end else begin
        mag_d  = {1'b0, magb_q - maga_q};
        sign_d = sigb_q;
      end
    end
    if (loadres) result_d = sign_q ? -mag_q : mag_q;
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      a_q      <= '0;
      b_q      <= '0;
      siga_q   <= 1'b0;
      sigb_q   <= 1'b0;
      maga_q   <= '0;
      magb_q   <= '0;
      ge_q     <= 1'b0;
      eq_q     <= 1'b0;
      mag_q    <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      siga_q   <= siga_d;
      sigb_q   <= sigb_d;
      maga_q   <= maga_d;
      magb_q   <= magb_d;
      ge_q     <= ge_d;
      eq_q     <= eq_d;
      mag_q    <= mag_d;
      sign_q   <= sign_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_adder2comp.sv
// ============================================================================
// tb_adder2comp: directed vectors with a result scoreboard for adder2comp.
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_adder2comp;
  import adder2comp_pkg::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         RESET;
  logic         S;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N:0]   result;
  logic         done;

`ifdef ADDER2COMP_DBG_EN
  logic p_loadAB, p_loadmagAB, p_compmag, p_compsigns, p_add_sub, p_loadres;
`endif

  adder2comp #(.N(N)) dut (
    .clk       (clk),
    .RESET     (RESET),
    .S         (S),
    .a         (a),
    .b         (b),
    .result    (result),
`ifdef ADDER2COMP_DBG_EN
    .loadAB    (p_loadAB),
    .loadmagAB (p_loadmagAB),
    .compmag   (p_compmag),
    .compsigns (p_compsigns),
    .add_sub   (p_add_sub),
    .loadres   (p_loadres),
`endif
    .done      (done)
  );

  always #5 clk = ~clk;

  logic [6:0] stb;
  assign stb = {dut.loadAB, dut.loadmagAB, dut.compmag, dut.compsigns,
                dut.add_sub, dut.loadres, dut.done};

  int         checks = 0;
  int         errors = 0;
  logic [N:0] exp_q[$];
  logic [N:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (done) begin
      if (exp_q.size() == 0) begin
        fail("unexpected_done");
      end else begin
        mon_exp = exp_q.pop_front();
        chk("result", {27'd0, result}, {27'd0, mon_exp});
      end
    end
  end

  // One operation with S pulsed for a single cycle; checks strobe order and latency.
  task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic [N:0] expv);
    bit got;
    @(posedge clk);
    @(negedge clk);
    a = ta;
    b = tb_v;
    S = 1'b1;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    S = 1'b0;
    got = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (cyc <= 7) chk("strobe_onehot", {25'd0, stb}, {25'd0, 7'b1000000 >> (cyc - 1)});
      if (cyc == 2) begin
        a = ~ta;
        b = ~tb_v;
      end
      if (done) begin
        chk("latency", cyc, 7);
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!got) fail("done_timeout");
  endtask

  initial begin
    RESET = 1'b1;
    S     = 1'b1;
    a     = 4'b0111;
    b     = 4'b0111;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_result", {27'd0, result}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_strobes", {25'd0, stb}, 32'd0);
    chk("reset_state", {29'd0, dut.u_uc.state_q}, {29'd0, IDLE});
    @(negedge clk);
    RESET = 1'b0;
    S     = 1'b0;

    run_op(4'b1110, 4'b1111, 5'b11101);
    run_op(4'b0101, 4'b1101, 5'b00010);
    run_op(4'b1101, 4'b0101, 5'b00010);
    run_op(4'b1000, 4'b1000, 5'b10000);
    run_op(4'b0111, 4'b0111, 5'b01110);
    run_op(4'b0011, 4'b1101, 5'b00000);
    run_op(4'b1000, 4'b0111, 5'b11111);
    run_op(4'b0111, 4'b1000, 5'b11111);
    run_op(4'b1000, 4'b0000, 5'b11000);
    run_op(4'b0010, 4'b0011, 5'b00101);

    // Abort an operation in ADD_SUB; the previous result (5) must be cleared.
    @(posedge clk);
    @(negedge clk);
    a = 4'b0110;
    b = 4'b0001;
    S = 1'b1;
    @(posedge clk);
    #1;
    S = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_in_addsub", {25'd0, stb}, 32'b0000100);
    RESET = 1'b1;
    #1;
    chk("abort_strobes_masked", {25'd0, stb}, 32'd0);
    @(posedge clk);
    #1;
    chk("abort_state", {29'd0, dut.u_uc.state_q}, {29'd0, IDLE});
    chk("abort_result", {27'd0, result}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    RESET = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_abort_done", {31'd0, done}, 32'd0);
    chk("post_abort_state", {29'd0, dut.u_uc.state_q}, {29'd0, IDLE});

    // Back-to-back operations with S held high.
    @(negedge clk);
    a = 4'b0101;
    b = 4'b1101;
    S = 1'b1;
    repeat (3) exp_q.push_back(5'b00010);
    @(posedge clk);
    #1;
    begin
      int ndone;
      ndone = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
        if (done) begin
          chk("b2b_done_cycle", cyc, 7 + 8 * ndone);
          ndone++;
          if (ndone == 3) begin
            S = 1'b0;
            break;
          end
        end
        @(posedge clk);
        #1;
      end
      if (ndone != 3) fail("b2b_timeout");
    end
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_stops_idle", {29'd0, dut.u_uc.state_q}, {29'd0, IDLE});
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout (t=%0t)", $time);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/adder2comp.md
ADDER2COMP -- requirements
Module: adder2comp

Interface
REQ-001 SHALL have parameter N, default 4, giving the operand width in bits (N >= 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port S, input, 1 bit: level-sensitive start request.
REQ-005 SHALL have ports a and b, input, N bits each: two's-complement operands.
REQ-006 SHALL have port result, output, N+1 bits: registered two's-complement sum.
REQ-007 SHALL have port done, output, 1 bit: high for exactly one cycle when result is valid.

Function
REQ-008 SHALL use the control states IDLE, LOAD_AB, LOAD_MAG, COMP_MAG, COMP_SIGNS, ADD_SUB, LOAD_RES, DONE, each lasting one cycle except IDLE.
REQ-009 SHALL go from IDLE to LOAD_AB when S=1 and stay in IDLE when S=0; the other states SHALL advance unconditionally in the order listed; DONE SHALL return to IDLE.
REQ-010 SHALL derive one strobe per non-IDLE state (loadAB, loadmagAB, compmag, compsigns, add_sub, loadres, done); the strobes SHALL be one-hot or all zero.
REQ-011 LOAD_AB SHALL register a, b and their sign bits; a and b SHALL be ignored in every other state.
REQ-012 LOAD_MAG SHALL register N-bit unsigned magnitudes (negated value when the sign is 1); -2^(N-1) SHALL give magnitude 2^(N-1).
REQ-013 COMP_MAG SHALL register the flag magA >= magB; COMP_SIGNS SHALL register the flag signA == signB.
REQ-014 ADD_SUB with equal signs SHALL register mag = magA+magB (N+1 bits) and sign = signA.
REQ-015 ADD_SUB with unequal signs SHALL register mag = larger minus smaller and sign = sign of the larger magnitude; equal magnitudes SHALL give sign 0.
REQ-016 LOAD_RES SHALL write result = sign ? -mag : mag (N+1 bits); overflow cannot occur.
REQ-017 result SHALL hold its value until the next LOAD_RES or reset; done SHALL be high only in DONE.
REQ-018 Latency SHALL be 7 cycles from the edge that samples S=1 in IDLE to done=1; result SHALL be valid in the done cycle.
REQ-019 With S held high, the unit SHALL restart from IDLE immediately after DONE, giving back-to-back 8-cycle operations.

Reset
REQ-020 RESET=1 at a rising edge SHALL force IDLE and clear all operand, magnitude, flag and sum registers and result to 0, at any state, including mid-operation.
REQ-021 During and right after reset, done and all strobes SHALL be 0; RESET SHALL take priority over S.

Configuration
REQ-022 With ADDER2COMP_DBG_EN defined, the six strobes loadAB, loadmagAB, compmag, compsigns, add_sub and loadres SHALL be extra 1-bit output ports.
REQ-023 Without ADDER2COMP_DBG_EN, those strobes SHALL be internal only; function and timing SHALL be identical in both cases.

Structure
REQ-024 Package adder2comp_pkg SHALL hold the state enumeration typedef and the default width constant.
REQ-025 The control FSM SHALL be the sub-module uc_adder2comp (inputs clk, RESET, S; outputs the strobes and done); the datapath SHALL sit in adder2comp.

Verification
REQ-026 a=1110 (-2), b=1111 (-1), S=1 -> result=11101 (-3) with done.
REQ-027 a=0101 (5), b=1101 (-3) -> result=00010; a=1101, b=0101 -> result=00010.
REQ-028 a=1000, b=1000 -> result=10000 (-16); a=0111, b=0111 -> result=01110 (14).
REQ-029 a=0011, b=1101 -> result=00000, sign 0.
REQ-030 RESET asserted during ADD_SUB -> next cycle IDLE, result=00000, done=0; with S=1 held, done pulses every 8 cycles, and the strobes are one-hot in state order.
